alu_response_checker: RTL and testbench

//  Synthesizable response checker on the ALU's output side. It captures each {SRC1, SRC2, ALU_CTRL} issue
//  and the ALU's {ALU_OUTPUT, Zero} reply, recomputes the golden result and compares the two. It keeps

---
 rtl/alu_response_checker.sv | 175 +++++++++++++++++
 tb/tb_alu_response_checker.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_response_checker.sv
// Response checker for a 64-bit ALU: recomputes the golden result for each accepted
// sample, compares it with the ALU reply and keeps pass/fail/illegal counters.
module alu_response_checker #(
  parameter int WIDTH        = 64,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SRC1,
  input  logic [WIDTH-1:0] SRC2,
  input  logic [3:0]       ALU_CTRL,
  input  logic [WIDTH-1:0] ALU_OUTPUT,
  input  logic             Zero,
  input  logic             clear,
  output logic             chk_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] illegal_count,
  output logic             halted,
  output logic [3:0]       fail_ctrl,
  output logic [WIDTH-1:0] fail_expected,
  output logic [WIDTH-1:0] fail_actual
);

  // Handshake: a sample transfers on a rising edge when in_valid & in_ready;
  // in_ready depends only on the FSM state, never on in_valid.
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t state_q, state_d;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_out_q;
  logic [3:0]       s1_ctrl_q;
  logic             s1_zero_q;

  logic             s2_valid_q, s2_legal_q, s2_mis_q;
  logic [3:0]       s2_ctrl_q;
  logic [WIDTH-1:0] s2_exp_q, s2_act_q;

  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, ill_q, ill_d;
  logic             cap_q, cap_d;
  logic [3:0]       fctrl_q, fctrl_d;
  logic [WIDTH-1:0] fexp_q, fexp_d, fact_q, fact_d;

  logic [WIDTH-1:0] golden;
  logic             legal, cmp_mis;
  logic             transfer;

  assign in_ready = (state_q == RUN);
  assign transfer = in_valid & in_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= transfer;
    end
    if (transfer) begin
      s1_a_q    <= SRC1;
      s1_b_q    <= SRC2;
      s1_ctrl_q <= ALU_CTRL;
      s1_out_q  <= ALU_OUTPUT;
      s1_zero_q <= Zero;
    end
  end

  always_comb begin
    golden = '0;
    legal  = 1'b1;
    case (s1_ctrl_q)
      4'b0000: golden = s1_a_q & s1_b_q;
      4'b0001: golden = s1_a_q | s1_b_q;
      4'b0010: golden = s1_a_q + s1_b_q;
      4'b0110: golden = s1_a_q - s1_b_q;
      4'b0111: golden = s1_b_q;
      4'b1100: golden = ~(s1_a_q | s1_b_q);
      default: legal  = 1'b0;
    endcase
    cmp_mis = (golden != s1_out_q) || ((golden == '0) != s1_zero_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_legal_q <= 1'b0;
      s2_mis_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_legal_q <= legal;
      s2_mis_q   <= legal & cmp_mis;
    end
    s2_ctrl_q <= s1_ctrl_q;
    s2_exp_q  <= golden;
    s2_act_q  <= s1_out_q;
  end

  assign chk_valid = s2_valid_q;
  assign mismatch  = s2_valid_q & s2_mis_q;

  // The judged sample is counted at the end of its chk_valid cycle; clear overrides it.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ill_d   = ill_q;
    cap_d   = cap_q;
    fctrl_d = fctrl_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;
    if (clear) begin
      state_d = RUN;
      pass_d  = '0;
      fail_d  = '0;
      ill_d   = '0;
      cap_d   = 1'b0;
      fctrl_d = '0;
      fexp_d  = '0;
      fact_d  = '0;
    end else if (s2_valid_q) begin
      if (!s2_legal_q) begin
        ill_d = sat_inc(ill_q);
      end else if (s2_mis_q) begin
        fail_d = sat_inc(fail_q);
        if (!cap_q) begin
          cap_d   = 1'b1;
          fctrl_d = s2_ctrl_q;
          fexp_d  = s2_exp_q;
          fact_d  = s2_act_q;
        end
        if (STOP_ON_FAIL != 0) state_d = HALTED;
      end else begin
        pass_d = sat_inc(pass_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pass_q  <= '0;
      fail_q  <= '0;
      ill_q   <= '0;
      cap_q   <= 1'b0;
      fctrl_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ill_q   <= ill_d;
      cap_q   <= cap_d;
      fctrl_q <= fctrl_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
    end
  end

  assign pass_count    = pass_q;
  assign fail_count    = fail_q;
  assign illegal_count = ill_q;
  assign halted        = (state_q == HALTED);
  assign fail_ctrl     = fctrl_q;
  assign fail_expected = fexp_q;
  assign fail_actual   = fact_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Bench for alu_response_checker: directed vector table, multi-cycle corner sequences
// and randomized streams checked against an arithmetic reference model.
module tb_alu_response_checker;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, clear, zero_in;
  logic [W-1:0] src1, src2, alu_out;
  logic [3:0]   alu_ctrl;

  logic         rdy_h, cv_h, mis_h, halt_h;
  logic [15:0]  pass_h, fail_h, ill_h;
  logic [3:0]   fctrl_h;
  logic [W-1:0] fexp_h, fact_h;

  logic         rdy_n, cv_n, mis_n, halt_n;
  logic [15:0]  pass_n, fail_n, ill_n;
  logic [3:0]   fctrl_n;
  logic [W-1:0] fexp_n, fact_n;

  logic         rdy_s, cv_s, mis_s, halt_s;
  logic [2:0]   pass_s, fail_s, ill_s;
  logic [3:0]   fctrl_s;
  logic [W-1:0] fexp_s, fact_s;

  alu_response_checker #(.WIDTH(W), .CNT_W(16), .STOP_ON_FAIL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_h),
    .SRC1(src1), .SRC2(src2), .ALU_CTRL(alu_ctrl), .ALU_OUTPUT(alu_out), .Zero(zero_in),
    .clear(clear), .chk_valid(cv_h), .mismatch(mis_h), .pass_count(pass_h),
    .fail_count(fail_h), .illegal_count(ill_h), .halted(halt_h), .fail_ctrl(fctrl_h),
    .fail_expected(fexp_h), .fail_actual(fact_h));

  alu_response_checker #(.WIDTH(W), .CNT_W(16), .STOP_ON_FAIL(0)) dut_ns (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_n),
    .SRC1(src1), .SRC2(src2), .ALU_CTRL(alu_ctrl), .ALU_OUTPUT(alu_out), .Zero(zero_in),
    .clear(clear), .chk_valid(cv_n), .mismatch(mis_n), .pass_count(pass_n),
    .fail_count(fail_n), .illegal_count(ill_n), .halted(halt_n), .fail_ctrl(fctrl_n),
    .fail_expected(fexp_n), .fail_actual(fact_n));

  alu_response_checker #(.WIDTH(W), .CNT_W(3), .STOP_ON_FAIL(0)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
    .SRC1(src1), .SRC2(src2), .ALU_CTRL(alu_ctrl), .ALU_OUTPUT(alu_out), .Zero(zero_in),
    .clear(clear), .chk_valid(cv_s), .mismatch(mis_s), .pass_count(pass_s),
    .fail_count(fail_s), .illegal_count(ill_s), .halted(halt_s), .fail_ctrl(fctrl_s),
    .fail_expected(fexp_s), .fail_actual(fact_s));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the opcode table in plain arithmetic
  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  // Scoreboard: expected mismatch bit per accepted sample, matched on chk_valid
  logic [0:0] exp_q[$];
  logic       mon_en  = 1'b0;
  logic       mon_sel = 1'b0;

  always @(negedge clk) begin
    if (mon_en && (mon_sel ? cv_n : cv_h)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_chk_valid", 1, 0);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        check("stream_mismatch", mon_sel ? mis_n : mis_h, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] o, input logic z);
    in_valid = 1'b1; alu_ctrl = op; src1 = a; src2 = b; alu_out = o; zero_in = z;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, out;
    logic         z;
    logic         exp_mis;
    int           kind;  // 0 pass, 1 fail, 2 illegal
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b, o;
    logic         z, bad, ready_ok;
    int           np, nf;
    logic [3:0]   first_op;
    logic         have_first;

    src1 = '0; src2 = '0; alu_out = '0; alu_ctrl = '0; zero_in = 1'b0;
    vecs[0] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 0};
    vecs[1] = '{4'b0110, 64'd0, 64'd1, 64'd0, 1'b1, 1'b1, 1};
    vecs[2] = '{4'b0011, 64'h1234, 64'h5678, 64'd7, 1'b0, 1'b0, 2};
    vecs[3] = '{4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 0};
    vecs[4] = '{4'b0001, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0, 1'b0, 0};
    vecs[5] = '{4'b0111, 64'hAAAA, 64'h5555, 64'h5555, 1'b0, 1'b0, 0};
    vecs[6] = '{4'b1100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0};
    vecs[7] = '{4'b0000, 64'hF0, 64'h0F, 64'd0, 1'b0, 1'b1, 1};
    vecs[8] = '{4'b0010, 64'd2, 64'd3, 64'd6, 1'b0, 1'b1, 1};
    vecs[9] = '{4'b1111, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 2};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_in_ready", rdy_h, 1);
    check("reset_chk_valid", cv_h, 0);
    check("reset_pass", pass_h, 0);
    check("reset_fail", fail_h, 0);
    check("reset_illegal", ill_h, 0);
    check("reset_halted", halt_h, 0);
    check("reset_fail_expected", fexp_h, 0);
    tick();

    // Directed vectors, each isolated by a clear pulse
    for (int i = 0; i < 10; i++) begin
      clear = 1'b1; tick(); clear = 1'b0;
      set_in(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].z);
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      if (vecs[i].kind != 2) check($sformatf("vec%0d_chk_valid", i), cv_h, 1);
      check($sformatf("vec%0d_mismatch", i), mis_h, vecs[i].exp_mis);
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_pass", i), pass_h, (vecs[i].kind == 0) ? 1 : 0);
      check($sformatf("vec%0d_fail", i), fail_h, (vecs[i].kind == 1) ? 1 : 0);
      check($sformatf("vec%0d_illegal", i), ill_h, (vecs[i].kind == 2) ? 1 : 0);
      check($sformatf("vec%0d_halted", i), halt_h, (vecs[i].kind == 1) ? 1 : 0);
      check($sformatf("vec%0d_in_ready", i), rdy_h, (vecs[i].kind == 1) ? 0 : 1);
      if (vecs[i].kind == 1) begin
        check($sformatf("vec%0d_fail_ctrl", i), fctrl_h, vecs[i].op);
        check($sformatf("vec%0d_fail_expected", i), fexp_h,
              ref_result(vecs[i].op, vecs[i].a, vecs[i].b));
        check($sformatf("vec%0d_fail_actual", i), fact_h, vecs[i].out);
      end
      tick();
    end

    // 100 back-to-back correct random samples
    do_reset();
    mon_sel = 1'b0; mon_en = 1'b1; ready_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op = legal_ops[$urandom_range(0, 5)];
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      o  = ref_result(op, a, b);
      set_in(op, a, b, o, (o == 0));
      exp_q.push_back(1'b0);
      @(negedge clk);
      if (!rdy_h) ready_ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    mon_en = 1'b0;
    check("b2b_pass_count", pass_h, 100);
    check("b2b_fail_count", fail_h, 0);
    check("b2b_in_ready_held", ready_ok, 1);
    check("b2b_queue_drained", exp_q.size(), 0);
    check("sat_pass_count", pass_s, 7);
    tick();

    // Non-halting checker: NOR fail then AND fail, only the first is captured
    do_reset();
    set_in(4'b1100, 64'd0, 64'd0, 64'd0, 1'b1);
    tick();
    set_in(4'b0000, 64'hFF, 64'h0F, 64'h01, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("ns_fail_count", fail_n, 2);
    check("ns_fail_ctrl", fctrl_n, 4'b1100);
    check("ns_fail_expected", fexp_n, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ns_fail_actual", fact_n, 0);
    check("ns_halted", halt_n, 0);
    check("ns_in_ready", rdy_n, 1);
    tick();

    // Random mixed stream on the non-halting checker
    do_reset();
    mon_sel = 1'b1; mon_en = 1'b1; np = 0; nf = 0; have_first = 1'b0; first_op = '0;
    for (int i = 0; i < 60; i++) begin
      op  = legal_ops[$urandom_range(0, 5)];
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      o   = ref_result(op, a, b);
      z   = (o == 0);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) begin
        if ($urandom_range(0, 1) == 0) o = o ^ (64'd1 << $urandom_range(0, 63));
        else z = ~z;
        nf++;
        if (!have_first) begin have_first = 1'b1; first_op = op; end
      end else begin
        np++;
      end
      set_in(op, a, b, o, z);
      exp_q.push_back(bad);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    mon_en = 1'b0;
    check("mix_pass_count", pass_n, np);
    check("mix_fail_count", fail_n, nf);
    check("mix_queue_drained", exp_q.size(), 0);
    if (have_first) check("mix_first_fail_ctrl", fctrl_n, first_op);
    check("mix_sat_pass", pass_s, (np > 7) ? 7 : np);
    check("mix_sat_fail", fail_s, (nf > 7) ? 7 : nf);
    tick();

    // Clear while halted with one sample in flight
    do_reset();
    set_in(4'b0110, 64'd0, 64'd1, 64'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    set_in(4'b0010, 64'd5, 64'd6, 64'd11, 1'b0);
    @(negedge clk);
    check("inflight_first_mismatch", mis_h, 1);
    tick();
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    check("inflight_halted", halt_h, 1);
    check("inflight_in_ready_low", rdy_h, 0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("after_clear_halted", halt_h, 0);
    check("after_clear_in_ready", rdy_h, 1);
    check("after_clear_fail", fail_h, 0);
    check("after_clear_chk_valid", cv_h, 1);
    check("after_clear_mismatch", mis_h, 0);
    tick();
    @(negedge clk);
    check("after_clear_pass", pass_h, 1);
    check("after_clear_fail2", fail_h, 0);
    tick();

    // Reset mid-stream discards the in-flight sample
    set_in(4'b0000, 64'h3, 64'h1, 64'h1, 1'b0);
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midreset_chk_valid%0d", i), cv_h, 0);
      tick();
    end
    @(negedge clk);
    check("midreset_pass", pass_h, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
